spi_master_ctrl: RTL

SPI master-side sequencer for the SPI slave/RAM subsystem. It accepts one RAM command at a time from a host-side request port and serialises it into a complete SPI frame on `ss_n`/`mosi`. For read-data commands it also captures the 8-bit reply from `miso` and returns it on a response port. It tracks the read-address/read-data ordering the slave requires and rejects read-data commands issued without a prior read-address.

---
 rtl/spi_master_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: serialises one {op, data} RAM command per frame on ss_n/mosi
// and captures the 8-bit MISO reply for read-data commands.
module spi_master_ctrl #(
    parameter int TURN_CYC = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       seq_err,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_SHIFT,
        S_TURN,
        S_RECV,
        S_RESP,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  frame_q, frame_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rd_pend_q, rd_pend_d;
    logic        seq_err_q, seq_err_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        handshake;

    assign handshake = req_valid && (state_q == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            frame_q    <= 10'd0;
            sh_q       <= 8'd0;
            rsp_data_q <= 8'd0;
            rd_pend_q  <= 1'b0;
            seq_err_q  <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            sh_q       <= sh_d;
            rsp_data_q <= rsp_data_d;
            rd_pend_q  <= rd_pend_d;
            seq_err_q  <= seq_err_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        sh_d       = sh_q;
        rsp_data_d = rsp_data_q;
        rd_pend_d  = rd_pend_q;
        unique case (state_q)
            S_IDLE: begin
                // A read-data without a preceding read-address is rejected in place.
                if (handshake && !(req_op == OP_RDATA && !rd_pend_q)) begin
                    state_d = S_CMD;
                    frame_d = {req_op, req_data};
                    cnt_d   = 4'd0;
                end
            end
            S_CMD: begin
                state_d = S_SHIFT;
                cnt_d   = 4'd9;
            end
            S_SHIFT: begin
                if (cnt_q == 4'd0) begin
                    if (frame_q[9:8] == OP_RDATA) begin
                        state_d = S_TURN;
                        cnt_d   = 4'(TURN_CYC - 1);
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = 4'(GAP_CYC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RECV;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RECV: begin
                sh_d = {sh_q[6:0], miso};
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    rsp_data_d = {sh_q[6:0], miso};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_GAP;
                cnt_d   = 4'(GAP_CYC - 1);
            end
            S_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    if (frame_q[9:8] == OP_RADDR) begin
                        rd_pend_d = 1'b1;
                    end else if (frame_q[9:8] == OP_RDATA) begin
                        rd_pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin drivers are registered from the next state so ss_n/mosi line up with the state they belong to.
    always_comb begin
        ss_n_d    = 1'b1;
        mosi_d    = 1'b0;
        seq_err_d = handshake && (req_op == OP_RDATA) && !rd_pend_q;
        unique case (state_d)
            S_CMD: begin
                ss_n_d = 1'b0;
                mosi_d = frame_d[9];
            end
            S_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = frame_d[cnt_d];
            end
            S_TURN, S_RECV: ss_n_d = 1'b0;
            default: ss_n_d = 1'b1;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign seq_err   = seq_err_q;
    assign ss_n      = ss_n_q;
    assign mosi      = mosi_q;

endmodule
